// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the IF-stage fetch controller.
package if_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus: redirect input, instruction memory port and the IF->ID handshake.
interface fetch_ctrl_if #(
    parameter int IMEM_W = 13
);
    logic              redirect_valid_i;
    logic [31:0]       redirect_pc_i;
    logic [IMEM_W-1:0] imem_addr_o;
    logic [31:0]       imem_instr_i;
    logic              if_valid_o;
    logic [31:0]       if_pc_o;
    logic [31:0]       if_instr_o;
    logic              id_ready_i;

    modport master (
        input  redirect_valid_i, redirect_pc_i, imem_instr_i, id_ready_i,
        output imem_addr_o, if_valid_o, if_pc_o, if_instr_o
    );

    modport slave (
        output redirect_valid_i, redirect_pc_i, imem_instr_i, id_ready_i,
        input  imem_addr_o, if_valid_o, if_pc_o, if_instr_o
    );
endinterface

// File: rtl/fetch_ctrl_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries with flush.
module fetch_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic         full,
    output logic         empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    fetch_entry_t     mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;

    // Pointer and occupancy bookkeeping; flush empties without touching storage.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; intentionally not reset, only pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push && !flush && !rst_i) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign full  = (count_r == CNT_FULL);
    assign empty = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage fetch controller: owns the PC, buffers fetched words, handles redirects.
module fetch_ctrl
    import if_pkg::*;
#(
    parameter int          IMEM_W     = 13,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    fetch_ctrl_if.master bus
);
    logic [31:0]  fetch_pc_r;
    logic         full_s;
    logic         empty_s;
    logic         push_s;
    logic         pop_s;
    fetch_entry_t wr_entry_s;
    fetch_entry_t head_s;

    // A full buffer may still accept a word when the head leaves in the same cycle.
    assign pop_s  = ~empty_s & bus.id_ready_i;
    assign push_s = ~bus.redirect_valid_i & (~full_s | pop_s);

    assign wr_entry_s.pc    = fetch_pc_r;
    assign wr_entry_s.instr = bus.imem_instr_i;

    // PC register: reset beats redirect, redirect beats sequential advance.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_r <= RESET_PC;
        end else if (bus.redirect_valid_i) begin
            fetch_pc_r <= {bus.redirect_pc_i[31:2], 2'b00};
        end else if (push_s) begin
            fetch_pc_r <= fetch_pc_r + PC_STEP;
        end else begin
            fetch_pc_r <= fetch_pc_r;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .flush (bus.redirect_valid_i),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (wr_entry_s),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    assign bus.imem_addr_o = fetch_pc_r[IMEM_W-1:0];
    assign bus.if_valid_o  = ~empty_s;
    assign bus.if_pc_o     = head_s.pc;
    assign bus.if_instr_o  = head_s.instr;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: queue-based reference model, directed scenarios and random traffic.
module tb_fetch_ctrl;
    import if_pkg::*;

    localparam int          IMEM_W   = 13;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam int          WORDS    = 1 << (IMEM_W - 2);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_ctrl_if #(.IMEM_W(IMEM_W)) bus ();

    fetch_ctrl #(
        .IMEM_W     (IMEM_W),
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    logic [31:0] mem [WORDS];
    assign bus.imem_instr_i = mem[bus.imem_addr_o[IMEM_W-1:2]];

    int checks   = 0;
    int failures = 0;

    // Reference: list of words ID has yet to receive, plus the next PC to fetch.
    fetch_entry_t exp_q[$];
    logic [31:0]  m_pc = RESET_PC;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return mem[pc[IMEM_W-1:2]];
    endfunction

    task automatic model_step();
        int           old_n;
        bit           taken;
        fetch_entry_t e;
        old_n = exp_q.size();
        taken = (old_n > 0) && (bus.id_ready_i == 1'b1);
        if (rst) begin
            exp_q.delete();
            m_pc = RESET_PC;
        end else if (bus.redirect_valid_i) begin
            exp_q.delete();
            m_pc = bus.redirect_pc_i & 32'hFFFF_FFFC;
        end else begin
            if (taken) void'(exp_q.pop_front());
            if (old_n < DEPTH || taken) begin
                e.pc    = m_pc;
                e.instr = word_at(m_pc);
                exp_q.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic compare();
        chk("if_valid", 32'(bus.if_valid_o), 32'(exp_q.size() != 0));
        chk("imem_addr", 32'(bus.imem_addr_o), 32'(m_pc[IMEM_W-1:0]));
        if (exp_q.size() != 0) begin
            chk("if_pc", bus.if_pc_o, exp_q[0].pc);
            chk("if_instr", bus.if_instr_o, exp_q[0].instr);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] pc);
        bus.redirect_valid_i = 1'b1;
        bus.redirect_pc_i    = pc;
        tick();
        bus.redirect_valid_i = 1'b0;
    endtask

    initial begin
        rst                  = 1'b1;
        bus.redirect_valid_i = 1'b0;
        bus.redirect_pc_i    = 32'h0;
        bus.id_ready_i       = 1'b1;
        for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
        mem[0] = 32'h0000_0013;
        mem[1] = 32'h0010_0093;
        mem[2] = 32'h0020_0113;

        // Streaming straight out of reset.
        do_reset();
        chk("rst_valid", 32'(bus.if_valid_o), 32'd0);
        chk("rst_addr", 32'(bus.imem_addr_o), 32'h0000_0000);
        tick();
        chk("first_pc", bus.if_pc_o, 32'h0000_0000);
        chk("first_instr", bus.if_instr_o, 32'h0000_0013);
        tick();
        chk("second_pc", bus.if_pc_o, 32'h0000_0004);
        chk("second_instr", bus.if_instr_o, 32'h0010_0093);
        tick();
        chk("third_pc", bus.if_pc_o, 32'h0000_0008);
        chk("third_instr", bus.if_instr_o, 32'h0020_0113);

        // Stall with a full buffer, then release.
        do_reset();
        bus.id_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("stall_addr", 32'(bus.imem_addr_o), 32'h0000_0008);
        chk("stall_head", bus.if_pc_o, 32'h0000_0000);
        bus.id_ready_i = 1'b1;
        tick();
        chk("release_pc1", bus.if_pc_o, 32'h0000_0004);
        tick();
        chk("release_pc2", bus.if_pc_o, 32'h0000_0008);

        // Redirect while streaming to a misaligned target.
        tick();
        tick();
        redirect(32'h0000_0102);
        chk("redir_bubble", 32'(bus.if_valid_o), 32'd0);
        tick();
        chk("redir_valid", 32'(bus.if_valid_o), 32'd1);
        chk("redir_pc", bus.if_pc_o, 32'h0000_0100);

        // Redirect with a full buffer and ID ready in the same cycle.
        bus.id_ready_i = 1'b0;
        tick();
        tick();
        bus.id_ready_i = 1'b1;
        redirect(32'h0000_0100);
        chk("full_redir_empty", 32'(bus.if_valid_o), 32'd0);
        tick();
        chk("full_redir_pc0", bus.if_pc_o, 32'h0000_0100);
        tick();
        chk("full_redir_pc1", bus.if_pc_o, 32'h0000_0104);
        tick();
        chk("full_redir_pc2", bus.if_pc_o, 32'h0000_0108);

        // PC wrap at the top of the address space.
        redirect(32'hFFFF_FFFC);
        chk("wrap_addr0", 32'(bus.imem_addr_o), 32'h0000_1FFC);
        tick();
        chk("wrap_pc0", bus.if_pc_o, 32'hFFFF_FFFC);
        chk("wrap_addr1", 32'(bus.imem_addr_o), 32'h0000_0000);
        tick();
        chk("wrap_pc1", bus.if_pc_o, 32'h0000_0000);

        // Single-cycle reset with a full buffer.
        bus.id_ready_i = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", 32'(bus.if_valid_o), 32'd0);
        bus.id_ready_i = 1'b1;
        tick();
        chk("midrst_pc", bus.if_pc_o, RESET_PC);

        // Random traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            bus.id_ready_i       = ($urandom_range(0, 3) != 0);
            bus.redirect_valid_i = ($urandom_range(0, 19) == 0);
            bus.redirect_pc_i    = ($urandom_range(0, 3) == 0) ?
                                   (32'hFFFF_FFF0 | ($urandom & 32'h0000_000F)) : $urandom;
            rst                  = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch controller for the IF stage. Owns the program counter, drives the word address into the combinational instruction memory, and captures each returned instruction with its PC into a small FIFO. Presents fetched instructions to decode (ID) over a valid/ready handshake. Handles redirects from branch/jump resolution by flushing and restarting fetch.

## Interface
- `IMEM_W`, default 13: byte-address width of the instruction memory.
- `RESET_PC`, default 32'h0000_0000: fetch PC after reset; bits [1:0] must be 0.
- `FIFO_DEPTH`, default 2: fetch buffer entries; power of two, ≥ 2.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `redirect_valid_i`  in  1  request to restart fetch at `redirect_pc_i`.
- `redirect_pc_i`  in  32  redirect target (byte address).
- `imem_addr_o`  out  IMEM_W  byte address to the instruction memory; equals `fetch_pc[IMEM_W-1:0]`.
- `imem_instr_i`  in  32  instruction word from memory; combinational response to `imem_addr_o`, same cycle.
- `if_valid_o`  out  1  FIFO head holds a valid instruction.
- `if_pc_o`  out  32  PC of the head entry.
- `if_instr_o`  out  32  instruction of the head entry.
- `id_ready_i`  in  1  decode accepts the head this cycle.

## Operation
- State:
  - `fetch_pc` (32b).
  - FIFO storage of {pc, instr} entries.
  - Read pointer and write pointer, each log2(FIFO_DEPTH) bits.
  - Occupancy `count`, 0..FIFO_DEPTH.
- `pop = if_valid_o & id_ready_i`.
- `push = ~redirect_valid_i & (count < FIFO_DEPTH | pop)`.
- On push:
  - write {`fetch_pc`, `imem_instr_i`} at the write pointer;
  - advance the write pointer;
  - `fetch_pc <= fetch_pc + 4`.
- On pop: advance the read pointer.
- Occupancy update: `count += push - pop`.
- Redirect has priority over push and pop:
  - `count <= 0`, both pointers to 0;
  - `fetch_pc <= {redirect_pc_i[31:2], 2'b00}`, so misaligned targets are force-aligned;
  - any head presented that cycle is discarded, even if `id_ready_i` is high. ID must treat a redirect cycle as non-transfer.
- Stall: with the FIFO full and `id_ready_i` low:
  - no push occurs;
  - `fetch_pc` holds, and `imem_addr_o` holds with it;
  - the head is stable.
- Full with pop in the same cycle: push is allowed, so sustained throughput is 1 instruction per cycle.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- `imem_addr_o` uses only the low IMEM_W bits, so the address aliases beyond the memory size. No fault is raised.
- Reset, including mid-operation:
  - `fetch_pc = RESET_PC`, `count = 0`, pointers 0;
  - `if_valid_o = 0`; `if_pc_o` and `if_instr_o` are don't-care when invalid;
  - `imem_addr_o = RESET_PC[IMEM_W-1:0]` in the cycle after reset;
  - reset overrides redirect.
- FIFO storage is not reset; only the pointers and `count` are.

## Timing
- `imem_addr_o` is a direct function of the `fetch_pc` register; no combinational path from any input.
- First valid instruction: `if_valid_o` rises in the first cycle after the first clock edge with `rst_i` low. That instruction is the one at RESET_PC.
- After a redirect in cycle N:
  - `if_valid_o` = 0 in cycle N+1;
  - the target instruction is valid in cycle N+2.
  - Redirect penalty is 2 cycles of bubbles.
- `if_valid_o`, `if_pc_o` and `if_instr_o` are driven from registers; no combinational path from `id_ready_i`.
- Back-to-back redirects: the last one wins; each restarts the 2-cycle penalty.

## Structure
- Package `if_pkg` holds:
  - `typedef struct packed {logic [31:0] pc; logic [31:0] instr;} fetch_entry_t;`
  - `localparam logic [31:0] PC_STEP = 32'd4`.
- Sub-module `fetch_fifo`:
  - parameterized synchronous FIFO of `fetch_entry_t` with push/pop/flush, full/empty;
  - `fetch_ctrl` instantiates it and holds the PC logic.

## Test plan
- Reset release with memory words 0x00000013, 0x00100093, 0x00200113 at word addresses 0..2, `id_ready_i = 1` → `if_valid_o` high from cycle 1. `if_pc_o` = 0x0, 0x4, 0x8 on consecutive cycles with the matching instructions.
- Hold `id_ready_i = 0` for 5 cycles → `count` saturates at 2 and `imem_addr_o` freezes at 0x8. On release, PCs 0x0, 0x4, 0x8 come out in order with no loss or duplicate.
- Redirect to 0x0000_0102 while streaming → next valid PC is 0x100 after exactly 2 bubble cycles. The head in the redirect cycle is not accepted.
- Redirect asserted together with `id_ready_i = 1` and a full FIFO → FIFO empties. Resulting `if_pc_o` sequence is 0x100, 0x104, 0x108.
- Redirect to 0xFFFF_FFFC → PCs 0xFFFF_FFFC then 0x0000_0000. `imem_addr_o` = 0x1FFC then 0x0000 with IMEM_W = 13.
- Assert `rst_i` for 1 cycle mid-stream with the FIFO full → `if_valid_o` = 0 the next cycle. Fetch restarts at RESET_PC with no stale entries emitted.
